// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode and ALU encodings for the multi-cycle control FSM
package ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, MEM, CMP, BR, HALT} state_e;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3, OP_XOR = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5, OP_LW = 4'h6, OP_SW = 4'h7, OP_BEQ = 4'h8, OP_BNE = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA, OP_HLT = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_XOR = 3'd4;
  function automatic logic [2:0] alu_dec(input logic [3:0] op);
    case (op)
      OP_SUB: return ALU_SUB;
      OP_AND: return ALU_AND;
      OP_OR: return ALU_OR;
      OP_XOR: return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: fetch/decode/execute/memory/writeback sequencer driving the datapath strobes
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          opcode,
  input  logic                zero_flag,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_src,
  output logic                ir_write,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_imm,
  output logic                reg_write,
  output logic                wb_sel_mem,
  output logic                zero_flag_enable,
  output logic                halted,
  output logic                illegal_op,
  output logic                bus_error
);
  localparam int CW = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
  state_e state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bus_err_q, bus_err_d, timeout;
  logic [2:0] alu;
  assign timeout = !mem_ready && cnt_q == CW'(MEM_TIMEOUT - 1);
  assign alu_op = ALU_OP_W'(alu);
  // Reset forces every strobe low combinationally so an aborted request drops at once.
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = '0;
    bus_err_d = bus_err_q;
    {pc_write, pc_src, ir_write, mem_req, mem_we, iord, alu_src_imm} = '0;
    {reg_write, wb_sel_mem, zero_flag_enable, halted, illegal_op} = '0;
    alu = ALU_ADD;
    bus_error = !reset && bus_err_q;
    if (!reset)
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            {ir_write, pc_write} = 2'b11;
            state_d = DECODE;
          end else if (timeout) begin
            bus_err_d = 1'b1;
            state_d = HALT;
          end else cnt_d = cnt_q + 1'b1;
        end
        DECODE: begin
          op_d = opcode;
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LW, OP_SW: state_d = EXEC;
            OP_BEQ, OP_BNE: state_d = CMP;
            OP_JMP: begin
              {pc_write, pc_src} = 2'b11;
              state_d = FETCH;
            end
            OP_HLT: state_d = HALT;
            default: begin
              illegal_op = 1'b1;
              state_d = FETCH;
            end
          endcase
        end
        EXEC: begin
          alu = alu_dec(op_q);
          alu_src_imm = op_q >= OP_ADDI;
          zero_flag_enable = op_q <= OP_ADDI;
          state_d = op_q <= OP_ADDI ? WB : MEM;
        end
        WB: begin
          reg_write = 1'b1;
          state_d = FETCH;
        end
        MEM: begin
          {mem_req, iord} = 2'b11;
          mem_we = op_q == OP_SW;
          if (mem_ready) begin
            {reg_write, wb_sel_mem} = {2{op_q == OP_LW}};
            state_d = FETCH;
          end else if (timeout) begin
            bus_err_d = 1'b1;
            state_d = HALT;
          end else cnt_d = cnt_q + 1'b1;
        end
        CMP: begin
          alu = ALU_SUB;
          zero_flag_enable = 1'b1;
          state_d = BR;
        end
        BR: begin
          {pc_write, pc_src} = {2{op_q == OP_BEQ ? zero_flag : !zero_flag}};
          state_d = FETCH;
        end
        HALT: halted = 1'b1;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= FETCH;
      op_q <= '0;
      cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      bus_err_q <= bus_err_d;
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed cycle-by-cycle check of the control FSM strobes
module tb_multicycle_ctrl_fsm;
  logic clk = 1'b0, reset, zero_flag, mem_ready;
  logic [3:0] opcode;
  logic pc_write, pc_src, ir_write, mem_req, mem_we, iord, alu_src_imm;
  logic reg_write, wb_sel_mem, zero_flag_enable, halted, illegal_op, bus_error;
  logic [2:0] alu_op;
  logic [15:0] obs;
  int checks = 0, errors = 0;
  typedef struct {string tag; logic [15:0] exp;} exp_t;
  exp_t sb[$];
  localparam logic [15:0] PCW = 16'h8000, PCS = 16'h4000, IRW = 16'h2000, MRQ = 16'h1000;
  localparam logic [15:0] MWE = 16'h0800, IORD = 16'h0400, IMM = 16'h0040, RW = 16'h0020;
  localparam logic [15:0] WBM = 16'h0010, ZFE = 16'h0008, HLT = 16'h0004, ILL = 16'h0002, BERR = 16'h0001;
  localparam logic [15:0] F = PCW | IRW | MRQ;
  localparam logic [15:0] TKN = PCW | PCS;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .ALU_OP_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero_flag(zero_flag), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .wb_sel_mem(wb_sel_mem), .zero_flag_enable(zero_flag_enable), .halted(halted),
    .illegal_op(illegal_op), .bus_error(bus_error)
  );

  always #5 clk = ~clk;
  assign obs = {pc_write, pc_src, ir_write, mem_req, mem_we, iord, alu_op, alu_src_imm,
                reg_write, wb_sel_mem, zero_flag_enable, halted, illegal_op, bus_error};

  function automatic logic [15:0] a(input int x);
    return 16'(x << 7);
  endfunction

  task automatic step(input string tag, input logic r, input logic [3:0] op, input logic zf,
                      input logic rdy, input logic [15:0] exp);
    exp_t e;
    reset = r;
    opcode = op;
    zero_flag = zf;
    mem_ready = rdy;
    sb.push_back('{tag, exp});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: outputs=%h expected=%h", e.tag, obs, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    step("reset0", 1, 0, 0, 0, 16'h0);
    step("reset1", 1, 0, 0, 1, 16'h0);
    step("add_fetch", 0, 4'h0, 0, 1, F);
    step("add_decode", 0, 4'h0, 0, 1, 16'h0);
    step("add_exec", 0, 4'h0, 0, 0, ZFE | a(0));
    step("add_wb", 0, 4'h0, 0, 1, RW);
    step("xor_fetch", 0, 4'h4, 0, 1, F);
    step("xor_decode", 0, 4'h4, 0, 0, 16'h0);
    step("xor_exec", 0, 4'h4, 0, 0, ZFE | a(4));
    step("xor_wb", 0, 4'h4, 0, 0, RW);
    step("addi_fetch", 0, 4'h5, 0, 1, F);
    step("addi_decode", 0, 4'h5, 0, 0, 16'h0);
    step("addi_exec", 0, 4'h5, 0, 0, ZFE | IMM | a(0));
    step("addi_wb", 0, 4'h5, 0, 0, RW);
    step("beq_fetch", 0, 4'h8, 0, 1, F);
    step("beq_decode", 0, 4'h8, 0, 0, 16'h0);
    step("beq_cmp", 0, 4'h8, 0, 0, ZFE | a(1));
    step("beq_br_taken", 0, 4'h8, 1, 0, TKN);
    step("bne_fetch", 0, 4'h9, 1, 1, F);
    step("bne_decode", 0, 4'h9, 1, 0, 16'h0);
    step("bne_cmp", 0, 4'h9, 1, 0, ZFE | a(1));
    step("bne_br_not", 0, 4'h9, 1, 0, 16'h0);
    step("bne2_fetch", 0, 4'h9, 0, 1, F);
    step("bne2_decode", 0, 4'h9, 0, 0, 16'h0);
    step("bne2_cmp", 0, 4'h9, 0, 0, ZFE | a(1));
    step("bne2_br_taken", 0, 4'h9, 0, 0, TKN);
    step("lw_fetch", 0, 4'h6, 0, 1, F);
    step("lw_decode", 0, 4'h6, 0, 0, 16'h0);
    step("lw_exec", 0, 4'h6, 0, 0, IMM | a(0));
    for (int i = 0; i < 3; i++) step("lw_mem_wait", 0, 4'h6, 0, 0, MRQ | IORD);
    step("lw_mem_ready", 0, 4'h6, 0, 1, MRQ | IORD | RW | WBM);
    step("jmp_fetch", 0, 4'hA, 0, 1, F);
    step("jmp_decode", 0, 4'hA, 0, 0, TKN);
    step("ill_fetch", 0, 4'hB, 0, 1, F);
    step("ill_decode", 0, 4'hB, 0, 1, ILL);
    step("ill_next_fetch", 0, 4'h7, 0, 1, F);
    step("sw_decode", 0, 4'h7, 0, 1, 16'h0);
    step("sw_exec", 0, 4'h7, 0, 1, IMM | a(0));
    step("sw_mem_wait", 0, 4'h7, 0, 0, MRQ | IORD | MWE);
    step("sw_reset", 1, 4'h7, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) step("to_fetch_wait", 0, 4'h0, 0, 0, MRQ);
    step("to_halt", 0, 4'h0, 0, 0, HLT | BERR);
    for (int i = 0; i < 3; i++) step("to_halt_hold", 0, 4'h0, 0, 1, HLT | BERR);
    step("halt_reset", 1, 4'h0, 0, 0, 16'h0);
    step("hlt_fetch", 0, 4'hF, 0, 1, F);
    step("hlt_decode", 0, 4'hF, 0, 0, 16'h0);
    for (int i = 0; i < 20; i++) step("hlt_hold", 0, 4'h0, i[0], i[1], HLT);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
